// File: rtl/tt_um_emern_vga_pkg.sv
// Shared 640x480@60 timing constants, blank colour and colour-bar table for the VGA driver.
// The colour-bar table is only used when VGA_TEST_PATTERN_EN is defined.
package tt_um_emern_vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned PIPE_LAT = 1;

    localparam logic [5:0] BLACK_COLOR = 6'h00;

    function automatic logic [5:0] bar_color(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'h3F;
            3'd1:    c = 6'h3C;
            3'd2:    c = 6'h0F;
            3'd3:    c = 6'h0C;
            3'd4:    c = 6'h33;
            3'd5:    c = 6'h30;
            3'd6:    c = 6'h03;
            default: c = 6'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tt_um_emern_sync_delay.sv
// WIDTH x DEPTH shift register with a synchronous active-high reset to a caller-supplied value.
module tt_um_emern_sync_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_val;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/tt_um_emern_vga_driver.sv
// VGA timing generator and output stage: counters, coordinate decode, pixel-aligned sync/rgb register.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module tt_um_emern_vga_driver
    import tt_um_emern_vga_pkg::*;
#(
    parameter int unsigned H_ACT    = H_ACTIVE,
    parameter int unsigned H_FRONT  = H_FP,
    parameter int unsigned H_SYNC_W = H_SYNC,
    parameter int unsigned H_BACK   = H_BP,
    parameter int unsigned V_ACT    = V_ACTIVE,
    parameter int unsigned V_FRONT  = V_FP,
    parameter int unsigned V_SYNC_W = V_SYNC,
    parameter int unsigned V_BACK   = V_BP,
    parameter int unsigned LAT      = PIPE_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] pixel_in,
    input  logic       test_mode,
    output logic [9:0] pixel_col,
    output logic [8:0] pixel_row,
    output logic       frame_start,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb_out
);

    localparam logic [9:0] H_LAST  = 10'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);
    localparam logic [9:0] H_ACT10 = 10'(H_ACT);
    localparam logic [9:0] V_ACT10 = 10'(V_ACT);
    localparam logic [9:0] HS_BEG  = 10'(H_ACT + H_FRONT);
    localparam logic [9:0] HS_END  = 10'(H_ACT + H_FRONT + H_SYNC_W);
    localparam logic [9:0] VS_BEG  = 10'(V_ACT + V_FRONT);
    localparam logic [9:0] VS_END  = 10'(V_ACT + V_FRONT + V_SYNC_W);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    logic h_act, v_act, active, hsync_raw, vsync_raw;

    assign h_act     = h_cnt_q < H_ACT10;
    assign v_act     = v_cnt_q < V_ACT10;
    assign active    = h_act && v_act;
    assign hsync_raw = !(h_cnt_q >= HS_BEG && h_cnt_q < HS_END);
    assign vsync_raw = !(v_cnt_q >= VS_BEG && v_cnt_q < VS_END);

    assign pixel_col   = h_act ? h_cnt_q : '0;
    assign pixel_row   = v_act ? v_cnt_q[8:0] : '0;
    // Gated by rst so the pulse only appears once counting has actually started.
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && !rst;
    assign vblank      = !v_act;

    logic active_dl, hs_dl, vs_dl;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DW = 6;
    logic [2:0] bar_idx, bar_dl;
    logic [DW-1:0] dl_in, dl_q;

    // Bar index = h_cnt / (H_ACT/8), built from threshold compares instead of a divider.
    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h_cnt_q >= 10'(i * (H_ACT / 8))) bar_idx = 3'(i);
        end
    end

    assign dl_in = {active, hsync_raw, vsync_raw, bar_idx};
    assign {active_dl, hs_dl, vs_dl, bar_dl} = dl_q;
`else
    localparam int unsigned DW = 3;
    logic [DW-1:0] dl_in, dl_q;
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign dl_in = {active, hsync_raw, vsync_raw};
    assign {active_dl, hs_dl, vs_dl} = dl_q;
`endif

    tt_um_emern_sync_delay #(
        .WIDTH(DW),
        .DEPTH(LAT)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .rst_val({1'b0, 1'b1, 1'b1, {(DW-3){1'b0}}}),
        .d      (dl_in),
        .q      (dl_q)
    );

    logic [5:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q;

    always_comb begin
        rgb_d = BLACK_COLOR;
        if (active_dl) begin
            rgb_d = pixel_in;
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) rgb_d = bar_color(bar_dl);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q   <= BLACK_COLOR;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hs_dl;
            vsync_q <= vs_dl;
        end
    end

    assign rgb_out = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule
